// File: rtl/esc_pkg.sv
`default_nettype none
// ============================================================================
// esc_pkg : widths, timing constant and FSM encoding shared by the ESC PWM
//           generator and decoder
// Revision: 1.0
// ============================================================================
package esc_pkg;

    localparam int ESC_MIN_HIGH = 6250;
    localparam int ESC_SPEED_W  = 11;
    localparam int ESC_HCNT_W   = 14;
    localparam int ESC_DIV_W    = 13;
    localparam int ESC_IDLE_W   = 22;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DIVIDE    = 2'd3
    } esc_state_t;

endpackage
`default_nettype wire

// File: rtl/div3_seq.sv
`default_nettype none
// ============================================================================
// div3_seq : sequential restoring divide-by-3, one quotient bit per clock,
//            done pulses exactly ESC_DIV_W cycles after start
// Revision: 1.0
// ============================================================================
module div3_seq
    import esc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ESC_DIV_W-1:0] dividend,
    output logic                 done,
    output logic [ESC_DIV_W-1:0] quotient
);

    logic [1:0]           rem;
    logic [ESC_DIV_W-1:0] shreg;
    logic [3:0]           cnt;
    logic                 busy;

    logic [1:0]           rem_src;
    logic [ESC_DIV_W-1:0] sh_src;
    logic [2:0]           trial;
    logic                 take;
    logic [1:0]           rem_next;
    logic [ESC_DIV_W-1:0] sh_next;

    // The first quotient bit is resolved on the start edge itself, so the
    // last one lands ESC_DIV_W-1 clocks later and done follows immediately.
    always_comb begin
        rem_src  = start ? 2'd0 : rem;
        sh_src   = start ? dividend : shreg;
        trial    = {rem_src, sh_src[ESC_DIV_W-1]};
        take     = (trial >= 3'd3);
        rem_next = take ? 2'(trial - 3'd3) : trial[1:0];
        sh_next  = {sh_src[ESC_DIV_W-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= 2'd0;
            shreg <= '0;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= rem_next;
                shreg <= sh_next;
                cnt   <= 4'(ESC_DIV_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem   <= rem_next;
                shreg <= sh_next;
                cnt   <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = shreg;

endmodule
`default_nettype wire

// File: rtl/esc_pwm_decoder.sv
`default_nettype none
// ============================================================================
// esc_pwm_decoder : measures ESC PWM high time, recovers the SPEED command,
//                   flags out-of-range pulses and loss of signal
// Revision: 1.0
// ============================================================================
module esc_pwm_decoder
    import esc_pkg::*;
#(
    parameter int MIN_HIGH  = ESC_MIN_HIGH,
    parameter int MAX_SPEED = 2047,
    parameter int SLACK     = 2,
    parameter int TIMEOUT   = 2500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwm_in,
    output logic [ESC_SPEED_W-1:0] speed,
    output logic                   valid,
    output logic                   err_range,
    output logic                   sig_lost
);

    localparam int                     MAX_HIGH = MIN_HIGH + 3 * MAX_SPEED + SLACK;
    localparam logic [ESC_HCNT_W-1:0]  HCNT_LO  = ESC_HCNT_W'(MIN_HIGH);
    localparam logic [ESC_HCNT_W-1:0]  HCNT_HI  = ESC_HCNT_W'(MAX_HIGH);
    localparam logic [ESC_HCNT_W-1:0]  HCNT_SAT = '1;
    localparam logic [ESC_IDLE_W-1:0]  IDLE_SAT = '1;
    localparam logic [ESC_IDLE_W-1:0]  IDLE_TO  = ESC_IDLE_W'(TIMEOUT);
    localparam logic [ESC_DIV_W-1:0]   Q_MAX    = ESC_DIV_W'(MAX_SPEED);

    logic sync1;
    logic pwm_s;
    logic pwm_d;
    logic rise;
    logic fall;

    esc_state_t            state;
    logic [ESC_HCNT_W-1:0] hcnt;
    logic [ESC_IDLE_W-1:0] idle_cnt;
    logic [ESC_IDLE_W-1:0] idle_next;
    logic                  idle_hit;
    logic                  in_range;

    logic                   div_start;
    logic                   div_done;
    logic [ESC_DIV_W-1:0]   div_dividend;
    logic [ESC_DIV_W-1:0]   div_q;
    logic [ESC_SPEED_W-1:0] speed_clamped;

    // Synchroniser resets high so no false rise is seen while a pulse that
    // straddles reset release is still in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            pwm_s <= 1'b1;
            pwm_d <= 1'b1;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d;
    assign fall = ~pwm_s & pwm_d;

    assign in_range      = (hcnt >= HCNT_LO) && (hcnt <= HCNT_HI);
    assign div_start     = (state == MEASURE) && fall && in_range;
    assign div_dividend  = ESC_DIV_W'(hcnt - HCNT_LO);
    assign speed_clamped = (div_q > Q_MAX) ? ESC_SPEED_W'(MAX_SPEED) : div_q[ESC_SPEED_W-1:0];

    assign idle_next = rise ? '0 : ((idle_cnt == IDLE_SAT) ? idle_cnt : idle_cnt + 1'b1);
    assign idle_hit  = (idle_next >= IDLE_TO);

    div3_seq u_div3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            hcnt      <= '0;
            idle_cnt  <= '0;
            speed     <= '0;
            valid     <= 1'b0;
            err_range <= 1'b0;
            sig_lost  <= 1'b0;
        end else begin
            valid    <= 1'b0;
            idle_cnt <= idle_next;
            if (idle_hit) begin
                sig_lost <= 1'b1;
            end
            case (state)
                ARM: begin
                    if (!pwm_s) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        hcnt  <= ESC_HCNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        if (in_range) begin
                            state <= DIVIDE;
                        end else begin
                            err_range <= 1'b1;
                            state     <= WAIT_RISE;
                        end
                    end else if (pwm_s && (hcnt != HCNT_SAT)) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                DIVIDE: begin
                    // A pulse already high when the divide finishes is dropped.
                    if (div_done) begin
                        speed     <= speed_clamped;
                        valid     <= 1'b1;
                        err_range <= 1'b0;
                        sig_lost  <= 1'b0;
                        state     <= pwm_s ? ARM : WAIT_RISE;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_decoder.sv
`default_nettype none
// ============================================================================
// tb_esc_pwm_decoder : randomized pulses checked against a pulse-level model
// Revision: 1.0
// ============================================================================
module tb_esc_pwm_decoder;

    localparam int MIN_HIGH  = 250;
    localparam int MAX_SPEED = 2047;
    localparam int SLACK     = 2;
    localparam int TIMEOUT   = 7000;
    localparam int MAX_HIGH  = MIN_HIGH + 3 * MAX_SPEED + SLACK;
    localparam int LATENCY   = 16;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pwm_in = 1'b0;
    logic [10:0] speed;
    logic        valid;
    logic        err_range;
    logic        sig_lost;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int last_speed = 0;
    int exp_cyc[$];
    int exp_spd[$];
    bit exp_now;

    esc_pwm_decoder #(
        .MIN_HIGH  (MIN_HIGH),
        .MAX_SPEED (MAX_SPEED),
        .SLACK     (SLACK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .speed     (speed),
        .valid     (valid),
        .err_range (err_range),
        .sig_lost  (sig_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Decoded speed for a pulse high for n clocks, or -1 if it is malformed.
    function automatic int exp_speed(input int n);
        int q;
        if (n < MIN_HIGH || n > MAX_HIGH) return -1;
        q = (n - MIN_HIGH) / 3;
        return (q > MAX_SPEED) ? MAX_SPEED : q;
    endfunction

    // Every valid strobe must match a scheduled decode, and vice versa.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_now = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
            if (valid || exp_now) begin
                check("valid", int'(valid), int'(exp_now));
                if (valid && exp_now) begin
                    check("speed", int'(speed), exp_spd[0]);
                    check("err_on_valid", int'(err_range), 0);
                    check("lost_on_valid", int'(sig_lost), 0);
                end
                if (exp_now) begin
                    void'(exp_cyc.pop_front());
                    void'(exp_spd.pop_front());
                end
            end
        end
    end

    task automatic pulse(input int n, input int gap);
        int s;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        rise_cyc = cyc;
        repeat (n) @(posedge clk);
        #1 pwm_in = 1'b0;
        s = exp_speed(n);
        if (s >= 0) begin
            exp_cyc.push_back(cyc + LATENCY);
            exp_spd.push_back(s);
        end
        repeat (gap) @(posedge clk);
        #1;
        if (s >= 0) begin
            check("speed_after", int'(speed), s);
            check("err_clear", int'(err_range), 0);
            last_speed = s;
        end else begin
            check("err_set", int'(err_range), 1);
            check("speed_kept", int'(speed), last_speed);
        end
    endtask

    task automatic do_reset_now();
        rst_n = 1'b0;
        exp_cyc.delete();
        exp_spd.delete();
        last_speed = 0;
        #1;
        check("rst_speed", int'(speed), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err_range), 0);
        check("rst_lost", int'(sig_lost), 0);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1 do_reset_now();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Boundaries and slack around a known command
        pulse(MIN_HIGH + 1, 30);
        pulse(MIN_HIGH + 3000 + 1, 30);
        pulse(MIN_HIGH + 3000, 30);
        pulse(MIN_HIGH + 3000 + 2, 30);

        // Generator-style periods: fixed corners then random commands
        pulse(MIN_HIGH + 3 * 0 + $urandom_range(0, SLACK), $urandom_range(20, 200));
        pulse(MIN_HIGH + 3 * 1 + $urandom_range(0, SLACK), $urandom_range(20, 200));
        pulse(MIN_HIGH + 3 * MAX_SPEED + $urandom_range(0, SLACK), $urandom_range(20, 200));
        for (int i = 0; i < 3; i++) begin
            s = $urandom_range(0, MAX_SPEED);
            pulse(MIN_HIGH + 3 * s + $urandom_range(0, SLACK), $urandom_range(20, 200));
        end

        // Malformed pulses leave speed alone; a good one recovers
        pulse(MIN_HIGH - 1, 30);
        pulse($urandom_range(1, MIN_HIGH - 2), 30);
        pulse(MAX_HIGH + 1, 30);
        pulse(MAX_HIGH, 30);
        pulse(MIN_HIGH + 3001, 30);

        // Loss of signal: asserts TIMEOUT clocks after the detected rise
        pulse(MIN_HIGH + 3 * 700, 20);
        while (cyc < rise_cyc + 2 + TIMEOUT) @(negedge clk);
        check("lost_early", int'(sig_lost), 0);
        @(negedge clk);
        check("lost_set", int'(sig_lost), 1);
        pulse(MIN_HIGH - 1, 30);
        check("lost_after_bad", int'(sig_lost), 1);
        pulse(MIN_HIGH + 3 * 700 + 1, 30);
        check("lost_cleared", int'(sig_lost), 0);

        // Reset in the middle of a pulse: remainder must not decode
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (1000) @(posedge clk);
        #1 do_reset_now();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("speed_after_rst_pulse", int'(speed), 0);
        pulse(MIN_HIGH + 3 * 1234 + 1, 30);

        // Reset during the divide
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (MIN_HIGH + 3 * 333) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (8) @(posedge clk);
        #1 do_reset_now();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("speed_after_rst_div", int'(speed), 0);
        pulse(MIN_HIGH + 3 * 42 + 2, 30);

        repeat (30) @(posedge clk);
        #1 check("pending_decodes", exp_cyc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
